// File: rtl/weight_buf_pkg.sv
// Shared definitions for the ping-pong weight buffer.
// Contents: default data/address widths, the loader state encoding and the
// page-select convention (physical bank address = {page, addr}, with the page
// bit as the MSB).
package weight_buf_pkg;

  localparam int unsigned DW_DEF         = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned DEPTH_DEF      = 2048;
  localparam int unsigned NUM_BANKS_DEF  = 16;

  // One page-select bit prepended to the in-page address.
  localparam int unsigned PAGE_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/weight_bank_sdp.sv
// One simple dual-port weight BRAM bank (WORDS x DW).
// Ports:
//   clk                  clock
//   we_i/waddr_i/wdata_i port A write
//   re_i/raddr_i         port B read enable/address
//   rdata_o              port B registered read data (valid 1 cycle after re_i)
// Contents are not reset.
module weight_bank_sdp #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 12,
  parameter int unsigned WORDS = 4096
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;

  // Port A write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Port B registered read.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_bram_pingpong.sv
// Double-buffered weight store: NUM_BANKS BRAM banks, each split into a
// ping and a pong page. A handshaked round-robin loader fills the shadow
// page while the PE array reads the active page; swap exchanges them.
// Ports:
//   clk, rst_n                      clock, async active-low reset (assumed
//                                   already release-synchronised upstream)
//   load_start, load_words          start a load of load_words words per bank
//   s_valid, s_ready, s_data        weight stream
//   load_busy, load_done, load_err  loader status
//   shadow_valid, swap, swap_err    page exchange control
//   active_page                     page served to readers
//   rd_en, rd_addr_flat             per-bank read requests
//   rd_data_flat, rd_valid          per-bank read results
// Build option: WEIGHT_BRAM_RD_REG_EN adds an output register stage per bank
// (read latency 2 instead of 1).
module weight_bram_pingpong
  import weight_buf_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned BANK_IDX_W = $clog2(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic [ADDR_WIDTH:0]             load_words,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DW-1:0]                   s_data,
  output logic                            load_busy,
  output logic                            load_done,
  output logic                            load_err,
  output logic                            shadow_valid,
  input  logic                            swap,
  output logic                            swap_err,
  output logic                            active_page,
  input  logic [NUM_BANKS-1:0]            rd_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr_flat,
  output logic [NUM_BANKS*DW-1:0]         rd_data_flat,
  output logic [NUM_BANKS-1:0]            rd_valid
);

  localparam int unsigned PHYS_AW = ADDR_WIDTH + PAGE_BITS;
  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;

  ld_state_e               state_q;
  logic [LEN_W-1:0]        len_q;
  logic [BANK_IDX_W-1:0]   bank_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_cnt_q;
  logic                    s_ready_q;
  logic                    load_busy_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic                    shadow_valid_q;
  logic                    swap_err_q;
  logic                    active_page_q;
  logic [NUM_BANKS-1:0]    rd_valid1_q;

  logic                    beat;
  logic                    last_bank;
  logic                    last_addr;
  logic [PHYS_AW-1:0]      wr_addr;

  assign beat      = (state_q == ST_LOAD) && s_valid && s_ready_q;
  assign last_bank = (bank_cnt_q == BANK_IDX_W'(NUM_BANKS - 1));
  assign last_addr = ({1'b0, addr_cnt_q} == (len_q - LEN_W'(1)));
  // Loader always writes the page readers are not using.
  assign wr_addr   = {~active_page_q, addr_cnt_q};

  // Loader FSM, swap control and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      bank_cnt_q     <= '0;
      addr_cnt_q     <= '0;
      s_ready_q      <= 1'b0;
      load_busy_q    <= 1'b0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      shadow_valid_q <= 1'b0;
      swap_err_q     <= 1'b0;
      active_page_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      swap_err_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            if (load_words == '0) begin
              load_done_q    <= 1'b1;
              shadow_valid_q <= 1'b1;
            end else begin
              state_q        <= ST_LOAD;
              len_q          <= (load_words > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_words;
              bank_cnt_q     <= '0;
              addr_cnt_q     <= '0;
              shadow_valid_q <= 1'b0;
              s_ready_q      <= 1'b1;
              load_busy_q    <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            load_err_q <= 1'b1;
          end
          if (beat) begin
            if (last_bank) begin
              bank_cnt_q <= '0;
              addr_cnt_q <= addr_cnt_q + ADDR_WIDTH'(1);
              if (last_addr) begin
                state_q     <= ST_DONE;
                s_ready_q   <= 1'b0;
                load_busy_q <= 1'b0;
                load_done_q <= 1'b1;
              end
            end else begin
              bank_cnt_q <= bank_cnt_q + BANK_IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (load_start) begin
            load_err_q <= 1'b1;
          end
          shadow_valid_q <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // shadow_valid is still low during DONE, so a swap there is rejected.
      if (swap) begin
        if (shadow_valid_q && (state_q == ST_IDLE)) begin
          active_page_q  <= ~active_page_q;
          shadow_valid_q <= 1'b0;
        end else begin
          swap_err_q <= 1'b1;
        end
      end
    end
  end

  // First read-valid stage tracks the BRAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid1_q <= '0;
    end else begin
      rd_valid1_q <= rd_en;
    end
  end

`ifdef WEIGHT_BRAM_RD_REG_EN
  logic [NUM_BANKS-1:0] rd_valid2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid2_q <= '0;
    end else begin
      rd_valid2_q <= rd_valid1_q;
    end
  end

  assign rd_valid = rd_valid2_q;
`else
  assign rd_valid = rd_valid1_q;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DW-1:0] bank_q;
    logic          wr_en;

    assign wr_en = beat && (bank_cnt_q == BANK_IDX_W'(g));

    // Page bit is taken in the rd_en cycle, so a read in the swap cycle sees the old page.
    weight_bank_sdp #(
      .DW    (DW),
      .AW    (PHYS_AW),
      .WORDS (2 * DEPTH)
    ) u_bank (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (s_data),
      .re_i    (rd_en[g]),
      .raddr_i ({active_page_q, rd_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH]}),
      .rdata_o (bank_q)
    );

`ifdef WEIGHT_BRAM_RD_REG_EN
    logic [DW-1:0] dout_q;

    // Output stage captures only fresh BRAM data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_valid1_q[g]) begin
        dout_q <= bank_q;
      end
    end

    assign rd_data_flat[g*DW +: DW] = dout_q;
`else
    assign rd_data_flat[g*DW +: DW] = bank_q;
`endif
  end

  assign s_ready      = s_ready_q;
  assign load_busy    = load_busy_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign shadow_valid = shadow_valid_q;
  assign swap_err     = swap_err_q;
  assign active_page  = active_page_q;

endmodule

// File: tb/tb_weight_bram_pingpong.sv
// Self-checking bench for weight_bram_pingpong (NUM_BANKS=4, DEPTH=8,
// ADDR_WIDTH=3). Expected read data comes from a bench-side page model and is
// queued when a read is issued; a monitor pops and compares on rd_valid.
// Honours WEIGHT_BRAM_RD_REG_EN for the expected read latency.
module tb_weight_bram_pingpong;

  localparam int DW  = 16;
  localparam int NB  = 4;
  localparam int AW  = 3;
  localparam int DEP = 8;
`ifdef WEIGHT_BRAM_RD_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          bank;
    logic [15:0] data;
    int          cyc;
  } sb_t;

  logic               clk;
  logic               rst_n;
  logic               load_start;
  logic [AW:0]        load_words;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic               load_busy;
  logic               load_done;
  logic               load_err;
  logic               shadow_valid;
  logic               swap;
  logic               swap_err;
  logic               active_page;
  logic [NB-1:0]      rd_en;
  logic [NB*AW-1:0]   rd_addr_flat;
  logic [NB*DW-1:0]   rd_data_flat;
  logic [NB-1:0]      rd_valid;

  int          total = 0;
  int          bad   = 0;
  int          cyc_cnt = 0;
  logic        exp_page = 1'b0;
  logic [15:0] model [NB][2][DEP];
  sb_t         sb [$];

  weight_bram_pingpong #(
    .DW         (DW),
    .NUM_BANKS  (NB),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEP),
    .BANK_IDX_W (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_words   (load_words),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .shadow_valid (shadow_valid),
    .swap         (swap),
    .swap_err     (swap_err),
    .active_page  (active_page),
    .rd_en        (rd_en),
    .rd_addr_flat (rd_addr_flat),
    .rd_data_flat (rd_data_flat),
    .rd_valid     (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_val(input int pat, input int k);
    case (pat)
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'(k * 3 + 100);
      default: return 16'(k);
    endcase
  endfunction

  // Scoreboard monitor: every valid lane must match the oldest queued read.
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rd_valid[b] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 64'(rd_valid), 64'(0));
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("rd_bank_order", 64'(b), 64'(e.bank));
          chk("rd_data", 64'(rd_data_flat[b*DW +: DW]), 64'(e.data));
          chk("rd_latency", 64'(cyc_cnt - e.cyc), 64'(LAT));
        end
      end
    end
  end

  // Drive a read of addr on all banks and queue the active-page model values.
  task automatic issue_rd(input int addr);
    int pg;
    pg = exp_page ? 1 : 0;
    rd_en = '1;
    for (int b = 0; b < NB; b++) begin
      sb_t e;
      rd_addr_flat[b*AW +: AW] = AW'(addr);
      e.bank = b;
      e.data = model[b][pg][addr];
      e.cyc  = cyc_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic rd_all(input int addr);
    issue_rd(addr);
    step();
    rd_en = '0;
    repeat (LAT) step();
  endtask

  // Run a load; returns in the cycle where load_done is visible.
  task automatic do_load(input int lw, input int pat, input bit thr,
                         input bit err_mid, input bit rd_during);
    int n, len, k, cyc, pg;
    len = (lw > DEP) ? DEP : lw;
    n   = len * NB;
    k   = 0;
    cyc = 0;
    pg  = exp_page ? 0 : 1;
    load_words = (AW+1)'(lw);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ld_busy_start", 64'(load_busy), 64'(1));
    chk("ld_ready_start", 64'(s_ready), 64'(1));
    chk("ld_shadow_clr", 64'(shadow_valid), 64'(0));
    while (k < n && cyc < 400) begin
      s_valid = thr ? (cyc % 2 == 0) : 1'b1;
      s_data  = word_val(pat, k);
      if (err_mid && cyc == 2) begin
        load_start = 1'b1;
        load_words = (AW+1)'(1);
      end
      if (rd_during) issue_rd(cyc % len);
      step();
      if (s_valid) begin
        model[k % NB][pg][k / NB] = s_data;
        k++;
      end
      s_valid = 1'b0;
      rd_en   = '0;
      if (err_mid && cyc == 2) begin
        chk("ld_err_pulse", 64'(load_err), 64'(1));
        load_start = 1'b0;
      end
      if (k < n) begin
        chk("ld_busy_mid", 64'(load_busy), 64'(1));
        chk("ld_done_early", 64'(load_done), 64'(0));
      end
      cyc++;
    end
    chk("ld_word_count", 64'(k), 64'(n));
    chk("ld_done", 64'(load_done), 64'(1));
    chk("ld_ready_done", 64'(s_ready), 64'(0));
    chk("ld_busy_done", 64'(load_busy), 64'(0));
    chk("ld_shadow_in_done", 64'(shadow_valid), 64'(0));
  endtask

  task automatic finish_load();
    step();
    chk("ld_done_clr", 64'(load_done), 64'(0));
    chk("ld_shadow_set", 64'(shadow_valid), 64'(1));
  endtask

  task automatic do_swap(input bit ok, input bit rd_in_swap, input int addr);
    if (rd_in_swap) issue_rd(addr);
    swap = 1'b1;
    step();
    swap  = 1'b0;
    rd_en = '0;
    if (ok) exp_page = ~exp_page;
    chk("swap_err", 64'(swap_err), 64'(!ok));
    chk("swap_page", 64'(active_page), 64'(exp_page));
    if (ok) chk("swap_shadow_clr", 64'(shadow_valid), 64'(0));
    step();
    chk("swap_err_clr", 64'(swap_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    load_start   = 1'b0;
    load_words   = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    swap         = 1'b0;
    rd_en        = '0;
    rd_addr_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_busy", 64'(load_busy), 64'(0));
    chk("rst_done", 64'(load_done), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    chk("rst_shadow", 64'(shadow_valid), 64'(0));
    chk("rst_swap_err", 64'(swap_err), 64'(0));
    chk("rst_page", 64'(active_page), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    rst_n = 1'b1;
    step();

    // Swap with nothing loaded is rejected.
    do_swap(1'b0, 1'b0, 0);

    // Basic load 0..7, swap, read addr1 -> {7,6,5,4}.
    do_load(2, 0, 1'b0, 1'b0, 1'b0);
    finish_load();
    do_swap(1'b1, 1'b0, 0);
    issue_rd(1);
    step();
    rd_en = '0;
    if (LAT == 2) step();
    chk("rd_valid_all", 64'(rd_valid), 64'(4'hF));
    chk("rd_addr1_flat", 64'(rd_data_flat), 64'h0007_0006_0005_0004);
    step();
    rd_all(0);

    // Throttled load; swap on the load_done cycle is rejected, next one accepted.
    do_load(2, 3, 1'b1, 1'b0, 1'b0);
    do_swap(1'b0, 1'b0, 0);
    chk("shadow_after_done", 64'(shadow_valid), 64'(1));
    do_swap(1'b1, 1'b0, 0);
    rd_all(0);
    rd_all(1);

    // load_start during LOAD: error pulse, original load keeps its length.
    do_load(2, 0, 1'b0, 1'b1, 1'b0);
    finish_load();
    do_swap(1'b1, 1'b0, 0);
    rd_all(1);

    // Active 0x7FFF page read while 0x8000 fills the shadow.
    do_load(2, 1, 1'b0, 1'b0, 1'b0);
    finish_load();
    do_swap(1'b1, 1'b0, 0);
    do_load(2, 2, 1'b0, 1'b0, 1'b1);
    finish_load();
    do_swap(1'b1, 1'b1, 1);
    rd_all(1);

    // Oversized length saturates to DEPTH.
    do_load(15, 3, 1'b0, 1'b0, 1'b0);
    finish_load();
    do_swap(1'b1, 1'b0, 0);
    rd_all(7);
    rd_all(3);

    // Zero-length load: immediate done and shadow_valid.
    load_words = '0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("zero_done", 64'(load_done), 64'(1));
    chk("zero_shadow", 64'(shadow_valid), 64'(1));
    chk("zero_busy", 64'(load_busy), 64'(0));
    step();
    chk("zero_done_clr", 64'(load_done), 64'(0));

    // Reset for one cycle in the middle of a load.
    load_words = (AW+1)'(2);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'hDEAD;
      step();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(load_busy), 64'(0));
    chk("midrst_shadow", 64'(shadow_valid), 64'(0));
    chk("midrst_ready", 64'(s_ready), 64'(0));
    chk("midrst_page", 64'(active_page), 64'(0));
    exp_page = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    do_load(1, 3, 1'b0, 1'b0, 1'b0);
    finish_load();
    do_swap(1'b1, 1'b0, 0);
    rd_all(0);

    repeat (4) step();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
